// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU shift path.
package alu_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int AMT_W_DEF = 4;

    typedef enum logic [1:0] {
        OP_LSR = 2'b00,
        OP_LSL = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    // Explicit encodings keep the legacy state numbering visible.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step: computes the next work value and the bit leaving it.
module shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data,
    input  shift_op_e        op,
    output logic [WIDTH-1:0] next_data,
    output logic             out_bit
);

    // Select fill bit and departing bit for the requested operation.
    always_comb begin
        next_data = data;
        out_bit   = data[0];
        case (op)
            OP_LSR: next_data = {1'b0, data[WIDTH-1:1]};
            OP_LSL: begin
                next_data = {data[WIDTH-2:0], 1'b0};
                out_bit   = data[WIDTH-1];
            end
            OP_ASR: next_data = {data[WIDTH-1], data[WIDTH-1:1]};
            OP_ROR: next_data = {data[0], data[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate controller: one bit position per clock,
// valid/ready on both request and response sides, carry and zero flags.
module shift_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             busy
);

    localparam int unsigned WIDTH_U = WIDTH;

    ctrl_state_e      state;
    logic [WIDTH-1:0] work;
    shift_op_e        op_q;
    logic [AMT_W-1:0] cnt;
    logic             carry;

    shift_op_e        req_op;
    int unsigned      amt_u;
    logic [AMT_W-1:0] k;
    logic [WIDTH-1:0] step_data;
    logic             step_bit;

    assign req_op = shift_op_e'(in_op);

    // Effective step count: rotates wrap modulo WIDTH, shifts saturate at WIDTH.
    always_comb begin
        amt_u = {{(32-AMT_W){1'b0}}, in_amt};
        if (req_op == OP_ROR) begin
            k = AMT_W'(amt_u % WIDTH_U);
        end else if (amt_u > WIDTH_U) begin
            k = AMT_W'(WIDTH_U);
        end else begin
            k = in_amt;
        end
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data      (work),
        .op        (op_q),
        .next_data (step_data),
        .out_bit   (step_bit)
    );

    // FSM, work register, counter and carry flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            op_q  <= OP_LSR;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_a;
                        op_q  <= req_op;
                        carry <= 1'b0;
                        cnt   <= k;
                        state <= (k != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    work  <= step_data;
                    carry <= step_bit;
                    cnt   <= cnt - 1'b1;
                    if (cnt == AMT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign out_result = work;
    assign out_carry  = carry;
    // Gated by DONE so the flag reads 0 out of reset although work is 0 then.
    assign out_zero   = (state == DONE) && (work == '0);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [3:0] in_amt;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_carry;
    logic       out_zero;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    shift_seq_ctrl #(
        .WIDTH (8),
        .AMT_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_amt     (in_amt),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble inputs to prove they are not resampled.
    task automatic start_job(input logic [7:0] a, input logic [3:0] amt, input logic [1:0] op);
        in_a     = a;
        in_amt   = amt;
        in_op    = op;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_a     = ~a;
        in_amt   = 4'hF;
        in_op    = ~op;
    endtask

    task automatic wait_done(input string tag, input int k, input logic [7:0] res,
                             input logic c, input logic z);
        int cyc = 0;
        int sh  = 0;
        while (!out_valid && cyc < 40) begin
            if (busy) sh++;
            step();
            cyc++;
        end
        chk({tag, ".latency"}, cyc, k);
        chk({tag, ".shift_cycles"}, sh, k);
        chk({tag, ".result"}, out_result, res);
        chk({tag, ".carry"}, out_carry, c);
        chk({tag, ".zero"}, out_zero, z);
        chk({tag, ".in_ready"}, in_ready, 0);
        chk({tag, ".busy"}, busy, 1);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, out_valid, 0);
        chk({tag, ".ready_back"}, in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_amt    = '0;
        in_op     = '0;
        out_ready = 1'b0;
        #12;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.result", out_result, 0);
        chk("rst.carry", out_carry, 0);
        chk("rst.zero", out_zero, 0);
        rst_n = 1'b1;
        step();

        // LSR 0xB4 >> 3 = 0x16, last out bit = 1
        start_job(8'hB4, 4'd3, 2'b00);
        wait_done("lsr3", 3, 8'h16, 1'b1, 1'b0);
        consume("lsr3");

        // ASR 0x90 by 12 saturates at 8: all sign bits
        start_job(8'h90, 4'd12, 2'b10);
        wait_done("asr12", 8, 8'hFF, 1'b1, 1'b0);
        consume("asr12");

        // ROR 0x01 by 9 -> k=1
        start_job(8'h01, 4'd9, 2'b11);
        wait_done("ror9", 1, 8'h80, 1'b1, 1'b0);
        consume("ror9");

        // LSL 0x81 by 1
        start_job(8'h81, 4'd1, 2'b01);
        wait_done("lsl1", 1, 8'h02, 1'b1, 1'b0);
        consume("lsl1");

        // k=0: result ready the cycle after accept, carry cleared
        start_job(8'h5A, 4'd0, 2'b00);
        wait_done("lsr0", 0, 8'h5A, 1'b0, 1'b0);
        consume("lsr0");

        // LSR 0x0F by 15 -> 0 after 8 steps, last out bit = 0
        start_job(8'h0F, 4'd15, 2'b00);
        wait_done("lsr15", 8, 8'h00, 1'b0, 1'b1);
        consume("lsr15");

        // ROR by WIDTH wraps to k=0
        start_job(8'h3C, 4'd8, 2'b11);
        wait_done("ror8", 0, 8'h3C, 1'b0, 1'b0);
        consume("ror8");

        // LSL 0x81 by 8: last bit out is original bit0 = 1
        start_job(8'h81, 4'd8, 2'b01);
        wait_done("lsl8", 8, 8'h00, 1'b1, 1'b1);
        consume("lsl8");

        // Backpressure with a competing request pending
        start_job(8'hB4, 4'd3, 2'b00);
        wait_done("bp", 3, 8'h16, 1'b1, 1'b0);
        in_a     = 8'h81;
        in_amt   = 4'd1;
        in_op    = 2'b01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp.hold_valid", out_valid, 1);
            chk("bp.hold_result", out_result, 8'h16);
            chk("bp.hold_carry", out_carry, 1);
            chk("bp.hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp.consumed", out_valid, 0);
        chk("bp.not_accepted_yet", busy, 0);
        step();
        in_valid = 1'b0;
        chk("bp.accepted_busy", busy, 1);
        chk("bp.accepted_in_ready", in_ready, 0);
        wait_done("bp_next", 1, 8'h02, 1'b1, 1'b0);
        consume("bp_next");

        // Asynchronous reset in the middle of a shift
        start_job(8'h90, 4'd12, 2'b10);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.in_ready", in_ready, 1);
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.result", out_result, 0);
        chk("midrst.carry", out_carry, 0);
        chk("midrst.zero", out_zero, 0);
        #3;
        rst_n = 1'b1;
        step();
        chk("midrst.idle_after", busy, 0);
        start_job(8'hB4, 4'd3, 2'b00);
        wait_done("after_rst", 3, 8'h16, 1'b1, 1'b0);
        consume("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequential controller that performs a variable-distance shift or rotate on an 8-bit operand, one bit position per clock.
- Accepts jobs over a valid/ready request port and holds the result on a valid/ready response port until it is taken.
- Sits between the ALU operation decoder and the result mux. It is the area-lean multi-cycle alternative to the fully combinational shifters.
- Also produces carry and zero flags for the status register.

Parameters:
- WIDTH, 8, operand/result width in bits.
- AMT_W, 4, shift-amount field width. Amounts 0..2^AMT_W-1 are accepted.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_a  in  WIDTH  operand.
- in_amt  in  AMT_W  shift distance.
- in_op  in  2  operation: 00 LSR, 01 LSL, 10 ASR, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  shifted operand.
- out_carry  out  1  last bit shifted or rotated out.
- out_zero  out  1  out_result == 0.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_result=0, out_carry=0, out_zero=0, internal count=0.
- Reset mid-operation: rst_n low in any state aborts the job immediately. No result is emitted.
- States:
  - IDLE: in_ready=1.
  - SHIFT: stepping.
  - DONE: out_valid=1.
- Acceptance: a request is accepted at a clock edge where in_valid && in_ready. At that edge the controller latches in_a into the work register, latches in_op, and clears the carry.
- Effective count k:
  - ROR: k = in_amt mod WIDTH.
  - LSR/LSL/ASR: k = min(in_amt, WIDTH).
- State after acceptance: SHIFT if k>0, else DONE.
- SHIFT, each cycle:
  - Apply a one-bit step to the work register.
  - Carry <= the bit leaving the register: bit0 for LSR/ASR/ROR, bit WIDTH-1 for LSL.
  - Decrement count. When count reaches 0, go to DONE.
- Fill rules per step:
  - LSR: 0 into MSB.
  - LSL: 0 into LSB.
  - ASR: replicate MSB.
  - ROR: old bit0 into MSB.
- Latency: out_valid rises in the cycle after the k-th edge following the acceptance edge. k=0 gives out_valid in the cycle after acceptance.
- Throughput: one job per k+2 cycles when out_ready is tied high.
- DONE:
  - out_result, out_carry and out_zero are stable while out_valid=1.
  - out_valid stays high until out_ready is sampled high. Then go to IDLE.
  - out_carry=0 when k=0.
- in_ready is low in SHIFT and DONE; in_valid is ignored there.
- out_ready high in DONE while in_valid is high: the result is consumed at that edge. The new request is not accepted before the following edge (no same-edge turnaround).
- in_amt >= WIDTH for LSR/LSL: result 0 after WIDTH cycles. For ASR the result is all sign bits.
- Inputs are sampled only at the acceptance edge. Later changes to in_* do not affect the job in flight.
- out_zero is derived from the registered result and is valid whenever out_valid=1.

Decomposition:
- Shared package alu_pkg:
  - shift_op_e enum {OP_LSR, OP_LSL, OP_ASR, OP_ROR}.
  - ctrl_state_e enum {IDLE, SHIFT, DONE}.
  - Constants WIDTH_DEF=8 and AMT_W_DEF=4.
- Sub-module shift_step: purely combinational one-bit step.
  - Inputs: data and op.
  - Outputs: next data and out-bit.
- The controller instantiates shift_step once. It owns the FSM, the counter and the flag registers.

Test Plan:
- LSR in_a=0xB4, in_amt=3 -> out_result=0x16, out_carry=1, out_zero=0, out_valid 3 edges after accept + 1 cycle.
- ASR in_a=0x90, in_amt=12 -> k=8, out_result=0xFF, out_carry=1, 8 SHIFT cycles observed on busy.
- ROR in_a=0x01, in_amt=9 -> k=1, out_result=0x80, out_carry=1. Then LSL in_a=0x81, in_amt=1 -> 0x02, carry=1.
- LSR in_a=0x5A, in_amt=0 -> out_result=0x5A, carry=0, out_valid the cycle after accept. Then LSR 0x0F, in_amt=15 -> 0x00, out_zero=1, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. A concurrent in_valid is not accepted until the edge after out_ready=1.
- Pull rst_n low during SHIFT -> all outputs return to reset values immediately. A next job after release completes normally.
